// File: rtl/pixel_sink_pkg.sv
// Shared types and constants for the pixel sink: FSM state encoding,
// memory port widths and the linear-address helper.
package pixel_sink_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PIX_WRITE,
        CLR_WRITE
    } state_e;

    localparam int MEM_AW    = 19;
    localparam int MEM_DW    = 8;
    localparam int COORD_W   = 10;
    localparam int DEF_H_RES = 640;
    localparam int DEF_V_RES = 480;

    // Stride is always a parameter at the call site, so this folds into shift/add logic.
    function automatic logic [MEM_AW-1:0] linear_addr(input logic [COORD_W-1:0] x,
                                                      input logic [COORD_W-1:0] y,
                                                      input int unsigned        stride);
        logic [31:0] prod;
        prod = 32'(y) * stride + 32'(x);
        return prod[MEM_AW-1:0];
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Small power-of-two FIFO holding queued pixel coordinates between the
// line drawer and the memory write FSM.
module pixel_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/pixel_sink.sv
// Pixel sink: queues drawer pixels and writes them to frame memory, and clears
// the whole frame on request. Define PIXEL_SINK_CLIP_EN to drop off-screen pixels.
module pixel_sink
    import pixel_sink_pkg::*;
#(
    parameter int                H_RES       = DEF_H_RES,
    parameter int                V_RES       = DEF_V_RES,
    parameter int                FIFO_DEPTH  = 4,
    parameter logic [MEM_DW-1:0] PIXEL_VALUE = 8'hFF
) (
    input  logic              pclk,
    input  logic              reset_l,
    input  logic              wr,
    input  logic [COORD_W-1:0] addr_x,
    input  logic [COORD_W-1:0] addr_y,
    output logic              wrready,
    input  logic              clr_go,
    output logic              clr_busy,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [MEM_DW-1:0] mem_data,
    input  logic              mem_ready
);

    localparam logic [MEM_AW-1:0] LAST_ADDR = MEM_AW'(H_RES * V_RES - 1);

    state_e              state_q, state_d;
    logic                mem_we_q, mem_we_d;
    logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
    logic [MEM_DW-1:0]   mem_data_q, mem_data_d;
    logic                clr_busy_q, clr_busy_d;

    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [2*COORD_W-1:0] fifo_head;
    logic                in_range;

`ifdef PIXEL_SINK_CLIP_EN
    assign in_range = (int'(addr_x) < H_RES) && (int'(addr_y) < V_RES);
`else
    assign in_range = 1'b1;
`endif

    assign wrready   = !fifo_full && !clr_busy_q;
    assign fifo_push = wr && wrready && in_range;

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2*COORD_W)
    ) u_fifo (
        .clk     (pclk),
        .rst_n   (reset_l),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  ({addr_y, addr_x}),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge pclk or negedge reset_l) begin
        if (!reset_l) begin
            state_q    <= IDLE;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            clr_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            clr_busy_q <= clr_busy_d;
        end
    end

    // Queued pixels always drain ahead of a pending clear.
    always_comb begin
        state_d    = state_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        clr_busy_d = clr_busy_q;
        fifo_pop   = 1'b0;

        if (clr_go && !clr_busy_q) clr_busy_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_d    = PIX_WRITE;
                    mem_we_d   = 1'b1;
                    mem_addr_d = linear_addr(fifo_head[COORD_W-1:0],
                                             fifo_head[2*COORD_W-1:COORD_W], H_RES);
                    mem_data_d = PIXEL_VALUE;
                end else if (clr_busy_q) begin
                    state_d    = CLR_WRITE;
                    mem_we_d   = 1'b1;
                    mem_addr_d = '0;
                    mem_data_d = '0;
                end
            end
            PIX_WRITE: begin
                if (mem_ready) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        mem_addr_d = linear_addr(fifo_head[COORD_W-1:0],
                                                 fifo_head[2*COORD_W-1:COORD_W], H_RES);
                        mem_data_d = PIXEL_VALUE;
                    end else begin
                        state_d  = IDLE;
                        mem_we_d = 1'b0;
                    end
                end
            end
            CLR_WRITE: begin
                if (mem_ready) begin
                    if (mem_addr_q == LAST_ADDR) begin
                        state_d    = IDLE;
                        mem_we_d   = 1'b0;
                        clr_busy_d = 1'b0;
                    end else begin
                        mem_addr_d = mem_addr_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                mem_we_d = 1'b0;
            end
        endcase
    end

    assign clr_busy = clr_busy_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;

endmodule

// File: tb/tb_pixel_sink.sv
// Directed self-checking bench for pixel_sink; uses a 640x4 frame so a full
// clear stays short. Expectations follow PIXEL_SINK_CLIP_EN if it is defined.
module tb_pixel_sink;

    localparam int H = 640;
    localparam int V = 4;

    logic        pclk;
    logic        reset_l;
    logic        wr;
    logic [9:0]  addr_x;
    logic [9:0]  addr_y;
    logic        wrready;
    logic        clr_go;
    logic        clr_busy;
    logic        mem_we;
    logic [18:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;
    int weCycles = 0;
    logic [18:0] wrAddrQ [$];
    logic [7:0]  wrDataQ [$];

    pixel_sink #(
        .H_RES       (H),
        .V_RES       (V),
        .FIFO_DEPTH  (4),
        .PIXEL_VALUE (8'hFF)
    ) dut (
        .pclk      (pclk),
        .reset_l   (reset_l),
        .wr        (wr),
        .addr_x    (addr_x),
        .addr_y    (addr_y),
        .wrready   (wrready),
        .clr_go    (clr_go),
        .clr_busy  (clr_busy),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ready (mem_ready)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Inputs move at posedge+1, so the negedge sees exactly what the next edge will.
    always @(negedge pclk) begin
        if (reset_l) begin
            if (mem_we) weCycles++;
            if (mem_we && mem_ready) begin
                wrAddrQ.push_back(mem_addr);
                wrDataQ.push_back(mem_data);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic sendPixel(input int x, input int y, input int budget, output bit ok);
        wr = 1'b1;
        addr_x = 10'(x);
        addr_y = 10'(y);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge pclk);
            if (wrready) ok = 1'b1;
            @(posedge pclk);
            #1;
        end
        wr = 1'b0;
    endtask

    task automatic test_reset();
        reset_l = 1'b0; wr = 1'b0; addr_x = '0; addr_y = '0;
        clr_go = 1'b0; mem_ready = 1'b0;
        #12;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we got %b want 0", mem_we); end
        checks++; if (mem_addr !== 19'd0) begin errors++; $display("[TB] FAIL reset_mem_addr got %0d want 0", mem_addr); end
        checks++; if (mem_data !== 8'd0) begin errors++; $display("[TB] FAIL reset_mem_data got %h want 00", mem_data); end
        checks++; if (clr_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_clr_busy got %b want 0", clr_busy); end
        @(posedge pclk); #1;
        reset_l = 1'b1;
        @(negedge pclk);
        checks++; if (wrready !== 1'b1) begin errors++; $display("[TB] FAIL reset_wrready got %b want 1", wrready); end
        @(posedge pclk); #1;
    endtask

    task automatic test_single_write();
        bit ok;
        int base, we0;
        mem_ready = 1'b1;
        base = wrAddrQ.size();
        we0 = weCycles;
        sendPixel(10, 2, 5, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL single_accept got %b want 1", ok); end
        @(negedge pclk);
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL single_latency0 got %b want 0", mem_we); end
        @(negedge pclk);
        checks++; if (mem_we !== 1'b1) begin errors++; $display("[TB] FAIL single_latency1 got %b want 1", mem_we); end
        repeat (5) @(negedge pclk);
        checks++; if (wrAddrQ.size() - base != 1) begin errors++; $display("[TB] FAIL single_count got %0d want 1", wrAddrQ.size() - base); end
        checks++; if (weCycles - we0 != 1) begin errors++; $display("[TB] FAIL single_we_cycles got %0d want 1", weCycles - we0); end
        if (wrAddrQ.size() > base) begin
            checks++; if (wrAddrQ[base] !== 19'd1290) begin errors++; $display("[TB] FAIL single_addr got %0d want 1290", wrAddrQ[base]); end
            checks++; if (wrDataQ[base] !== 8'hFF) begin errors++; $display("[TB] FAIL single_data got %h want FF", wrDataQ[base]); end
        end
        @(posedge pclk); #1;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int accepted, base;
        int expAddr [6];
        for (int i = 0; i < 6; i++) expAddr[i] = (1 + i) * H + 10 + i;
        mem_ready = 1'b0;
        base = wrAddrQ.size();
        accepted = 0;
        for (int i = 0; i < 5; i++) begin
            sendPixel(10 + i, 1 + i, 3, ok);
            if (ok) accepted++;
        end
        sendPixel(15, 6, 4, ok);
        checks++; if (accepted != 5) begin errors++; $display("[TB] FAIL b2b_accepted got %0d want 5", accepted); end
        checks++; if (ok !== 1'b0) begin errors++; $display("[TB] FAIL b2b_full_blocks got %b want 0", ok); end
        @(negedge pclk);
        checks++; if (mem_we !== 1'b1) begin errors++; $display("[TB] FAIL b2b_we_held got %b want 1", mem_we); end
        checks++; if (mem_addr !== 19'(expAddr[0])) begin errors++; $display("[TB] FAIL b2b_addr_held got %0d want %0d", mem_addr, expAddr[0]); end
        @(posedge pclk); #1;
        mem_ready = 1'b1;
        sendPixel(15, 6, 10, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL b2b_sixth_accept got %b want 1", ok); end
        repeat (15) @(negedge pclk);
        checks++; if (wrAddrQ.size() - base != 6) begin errors++; $display("[TB] FAIL b2b_count got %0d want 6", wrAddrQ.size() - base); end
        for (int i = 0; i < 6 && base + i < wrAddrQ.size(); i++) begin
            checks++;
            if (wrAddrQ[base + i] !== 19'(expAddr[i]) || wrDataQ[base + i] !== 8'hFF) begin
                errors++;
                $display("[TB] FAIL b2b_write%0d got %0d/%h want %0d/FF", i, wrAddrQ[base + i], wrDataQ[base + i], expAddr[i]);
            end
        end
        @(posedge pclk); #1;
    endtask

    task automatic test_clear();
        bit ok;
        bit done;
        int base, viol, bad, firstBad;
        mem_ready = 1'b0;
        base = wrAddrQ.size();
        sendPixel(20, 0, 3, ok);
        sendPixel(21, 0, 3, ok);
        clr_go = 1'b1;
        @(posedge pclk); #1;
        clr_go = 1'b0;
        @(negedge pclk);
        checks++; if (clr_busy !== 1'b1) begin errors++; $display("[TB] FAIL clear_busy_set got %b want 1", clr_busy); end
        checks++; if (wrready !== 1'b0) begin errors++; $display("[TB] FAIL clear_wrready got %b want 0", wrready); end
        @(posedge pclk); #1;
        mem_ready = 1'b1;
        viol = 0;
        done = 1'b0;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge pclk);
            if (!clr_busy) done = 1'b1;
            else if (wrready) viol++;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL clear_timeout got busy=%b want 0", clr_busy); end
        checks++; if (viol != 0) begin errors++; $display("[TB] FAIL clear_wrready_busy got %0d cycles want 0", viol); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL clear_we_after got %b want 0", mem_we); end
        checks++; if (wrAddrQ.size() - base != 2 + H * V) begin errors++; $display("[TB] FAIL clear_count got %0d want %0d", wrAddrQ.size() - base, 2 + H * V); end
        if (wrAddrQ.size() - base >= 2 + H * V) begin
            checks++;
            if (wrAddrQ[base] !== 19'd20 || wrAddrQ[base + 1] !== 19'd21) begin
                errors++;
                $display("[TB] FAIL clear_pixels_first got %0d,%0d want 20,21", wrAddrQ[base], wrAddrQ[base + 1]);
            end
            bad = 0;
            firstBad = -1;
            for (int i = 0; i < H * V; i++) begin
                if (wrAddrQ[base + 2 + i] !== 19'(i) || wrDataQ[base + 2 + i] !== 8'h00) begin
                    if (firstBad < 0) firstBad = i;
                    bad++;
                end
            end
            checks++; if (bad != 0) begin errors++; $display("[TB] FAIL clear_sequence got %0d bad entries (first at %0d) want 0", bad, firstBad); end
        end
        @(posedge pclk); #1;
    endtask

    task automatic test_clip();
        bit ok;
        int base;
        mem_ready = 1'b1;
        base = wrAddrQ.size();
        sendPixel(700, 5, 5, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL clip_accept got %b want 1", ok); end
        repeat (6) @(negedge pclk);
`ifdef PIXEL_SINK_CLIP_EN
        checks++; if (wrAddrQ.size() - base != 0) begin errors++; $display("[TB] FAIL clip_dropped got %0d writes want 0", wrAddrQ.size() - base); end
`else
        checks++; if (wrAddrQ.size() - base != 1) begin errors++; $display("[TB] FAIL clip_count got %0d writes want 1", wrAddrQ.size() - base); end
        if (wrAddrQ.size() > base) begin
            checks++; if (wrAddrQ[base] !== 19'd3900) begin errors++; $display("[TB] FAIL clip_addr got %0d want 3900", wrAddrQ[base]); end
        end
`endif
        @(posedge pclk); #1;
    endtask

    task automatic test_reset_mid_clear();
        bit found;
        int snap;
        mem_ready = 1'b1;
        clr_go = 1'b1;
        @(posedge pclk); #1;
        clr_go = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge pclk);
            if (mem_we && mem_addr == 19'd100) found = 1'b1;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("[TB] FAIL midclr_reach100 got addr %0d want 100", mem_addr); end
        #2;
        reset_l = 1'b0;
        #1;
        snap = wrAddrQ.size();
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL midclr_we got %b want 0", mem_we); end
        checks++; if (clr_busy !== 1'b0) begin errors++; $display("[TB] FAIL midclr_busy got %b want 0", clr_busy); end
        checks++; if (mem_addr !== 19'd0) begin errors++; $display("[TB] FAIL midclr_addr got %0d want 0", mem_addr); end
        @(posedge pclk); #1;
        reset_l = 1'b1;
        repeat (20) @(negedge pclk);
        checks++; if (wrAddrQ.size() != snap) begin errors++; $display("[TB] FAIL midclr_no_resume got %0d writes want 0", wrAddrQ.size() - snap); end
        checks++; if (mem_we !== 1'b0 || clr_busy !== 1'b0) begin errors++; $display("[TB] FAIL midclr_idle got we=%b busy=%b want 0/0", mem_we, clr_busy); end
        checks++; if (wrready !== 1'b1) begin errors++; $display("[TB] FAIL midclr_wrready got %b want 1", wrready); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_clear();
        test_clip();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_sink.md
PIXEL_SINK -- requirements
Module: pixel_sink

Interface
REQ-001 Parameter H_RES, 640, visible pixels per row; row stride for linear address.
REQ-002 Parameter V_RES, 480, visible rows.
REQ-003 Parameter FIFO_DEPTH, 4, pixel FIFO entries (power of two, >=2).
REQ-004 Parameter PIXEL_VALUE, 8'hFF, intensity written for each plotted pixel.
REQ-005 pclk  input  1  sole clock; all logic on rising edge.
REQ-006 reset_l  input  1  asynchronous, active-low reset.
REQ-007 wr  input  1  pixel write strobe from line drawer.
REQ-008 addr_x  input  10  pixel column.
REQ-009 addr_y  input  10  pixel row.
REQ-010 wrready  output  1  sink can accept a pixel this cycle.
REQ-011 clr_go  input  1  single-cycle request to clear whole frame.
REQ-012 clr_busy  output  1  clear pending or in progress.
REQ-013 mem_we  output  1  memory write request.
REQ-014 mem_addr  output  19  linear address, addr_y*H_RES+addr_x.
REQ-015 mem_data  output  8  write data.
REQ-016 mem_ready  input  1  memory accepts write when mem_we && mem_ready.

Function
REQ-017 Pixel SHALL be accepted on any rising edge where wr=1 and wrready=1; wr while wrready=0 is ignored (drawer holds coordinates).
REQ-018 wrready SHALL be 1 iff FIFO not full and clr_busy=0; combinational from registered state only.
REQ-019 FSM states: IDLE, PIX_WRITE, CLR_WRITE; reset state IDLE.
REQ-020 IDLE -> PIX_WRITE when FIFO non-empty: pop head, register mem_addr=y*H_RES+x (19-bit, truncated), mem_data=PIXEL_VALUE, mem_we=1.
REQ-021 Latency: pixel accepted at edge N into empty FIFO, idle FSM -> mem_we=1 from edge N+1 to completion.
REQ-022 PIX_WRITE holds mem_we/addr/data stable until mem_ready=1; on that edge pop next entry back-to-back if FIFO non-empty (one write per cycle sustained), else IDLE with mem_we=0.
REQ-023 Simultaneous push and pop on full FIFO SHALL not occur (wrready=0 when full); push and pop on non-full FIFO both take effect.
REQ-024 clr_go SHALL set clear-pending (clr_busy=1 next cycle); clr_go while clr_busy=1 ignored.
REQ-025 Clear SHALL start only when FIFO empty and no pixel write outstanding; queued pixels drain first.
REQ-026 CLR_WRITE issues mem_data=0 to addresses 0..H_RES*V_RES-1 ascending, one per mem_ready cycle; after last accepted write -> IDLE, clr_busy=0, mem_we=0.
REQ-027 FIFO pointers wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-028 Multiply SHALL be constant-stride (shift/add permitted); no combinational path from addr_x/addr_y to mem_addr.

Reset
REQ-029 reset_l low, any cycle: mem_we=0, mem_addr=0, mem_data=0, clr_busy=0, FIFO empty (wrready=1 after release), state IDLE.
REQ-030 Reset mid-write or mid-clear SHALL abort immediately; no write resumes after release.

Configuration
REQ-031 Macro PIXEL_SINK_CLIP_EN: defined -> pixels with addr_x>=H_RES or addr_y>=V_RES are accepted (handshake completes) but not queued, no memory write.
REQ-032 Undefined -> every accepted pixel queued; address computed and truncated to 19 bits, no range check.

Structure
REQ-033 Shared package holds state enum, MEM_AW=19, MEM_DW=8, default H_RES/V_RES.
REQ-034 FIFO SHALL be sub-module pixel_fifo (push/pop/full/empty, async active-low reset).

Verification
REQ-035 Reset, then wr=1 (10,2), mem_ready=1 -> one write, mem_addr=1290, mem_data=FF, mem_we 1 cycle.
REQ-036 Six pixels back-to-back, mem_ready=0 -> wrready low after 4 accepted (+1 in output reg); release -> six writes in order, none lost/duplicated.
REQ-037 clr_go with 2 pixels queued -> 2 pixel writes first, then 307200 zero writes addr 0..307199, clr_busy low after last; wrready=0 throughout.
REQ-038 CLIP_EN defined, pixel (700,5) -> accepted, no mem_we; undefined -> write at addr 3900.
REQ-039 reset_l low mid-clear at addr 100 -> mem_we=0 immediately, clr_busy=0, no further writes after release.
